// File: rtl/prng_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prng_pkg
//  Description : Shared types and constants for the PRNG arbiter slice:
//                draw-sequencer state encoding, LFSR geometry (31 bits,
//                taps 30 and 27) and the default non-zero seed.
//  Revision    : 1.0 - initial release
// ============================================================================
package prng_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int c_LFSR_W = 31;
    localparam int c_TAP_HI = 30;
    localparam int c_TAP_LO = 27;

    localparam logic [c_LFSR_W-1:0] c_DEFAULT_SEED = 31'd1;

    // The all-zero state is a lock-up state for an XOR LFSR, so a zero
    // seed is replaced by the default seed.
    function automatic logic [c_LFSR_W-1:0] fix_seed(input logic [c_LFSR_W-1:0] s);
        return (s == '0) ? c_DEFAULT_SEED : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr31_core.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr31_core
//  Description : 31-bit Fibonacci LFSR, polynomial x^31 + x^28 + 1.
//                Shifts left, inserting tap30 ^ tap27 at bit 0.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-high reset (loads SEED)
//                step_en  - advance the register one step
//                load_en  - load load_val (has priority over step_en)
//                load_val - value to load
//                state    - current register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr31_core
    import prng_pkg::*;
#(
    parameter logic [c_LFSR_W-1:0] SEED = c_DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_en,
    input  logic                load_en,
    input  logic [c_LFSR_W-1:0] load_val,
    output logic [c_LFSR_W-1:0] state
);

    logic [c_LFSR_W-1:0] r_state;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= SEED;
        end else if (load_en) begin
            r_state <= load_val;
        end else if (step_en) begin
            r_state <= {r_state[c_LFSR_W-2:0], r_state[c_TAP_LO] ^ r_state[c_TAP_HI]};
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/prng_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prng_arbiter
//  Description : Round-robin arbiter sharing one 31-bit LFSR between two
//                requesters. A grant runs STEPS LFSR steps, serialising the
//                pre-step bit 0 of each step into a byte (first bit lands in
//                bit 7), then presents the byte with a one-cycle valid.
//                A draw occupies 10 cycles: grant, 8 SHIFT, 1 DONE.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-high reset
//                req[1:0]  - request levels, sampled only in IDLE
//                gnt[1:0]  - one-hot grant, held for the whole draw
//                valid     - one-cycle strobe with a fresh byte on data
//                data[7:0] - last drawn byte, held between draws
//                busy      - state is not IDLE
//                seed_load - load seed in IDLE (PRNG_SEED_LOAD_EN only)
//                seed      - seed value, 0 maps to 1 (PRNG_SEED_LOAD_EN only)
//  Config      : define PRNG_SEED_LOAD_EN to add the runtime seed-load port.
//  Revision    : 1.0 - initial release
// ============================================================================
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int                  STEPS = 8,
    parameter logic [c_LFSR_W-1:0] SEED  = c_DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    output logic [1:0]          gnt,
    output logic                valid,
    output logic [7:0]          data,
    output logic                busy
`ifdef PRNG_SEED_LOAD_EN
    ,
    input  logic                seed_load,
    input  logic [c_LFSR_W-1:0] seed
`endif
);

    localparam int                 c_CNT_W    = $clog2(STEPS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STEPS - 1);

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_ptr;
    logic [1:0]          r_gnt;
    logic                r_valid;
    logic [7:0]          r_data;
    logic [7:0]          r_data_sr;

    logic                w_step_en;
    logic                w_load_en;
    logic [c_LFSR_W-1:0] w_load_val;
    logic [c_LFSR_W-1:0] w_lfsr;
    logic [7:0]          w_next_sr;
    logic                w_lfsr_unused;

`ifdef PRNG_SEED_LOAD_EN
    assign w_load_en  = (r_state == IDLE) && seed_load;
    assign w_load_val = fix_seed(seed);
`else
    assign w_load_en  = 1'b0;
    assign w_load_val = SEED;
`endif

    assign w_step_en = (r_state == SHIFT);

    lfsr31_core #(
        .SEED     (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_en  (w_step_en),
        .load_en  (w_load_en),
        .load_val (w_load_val),
        .state    (w_lfsr)
    );

    // Only the output bit feeds the byte; the rest of the state is internal.
    assign w_lfsr_unused = ^w_lfsr[c_LFSR_W-1:1];

    assign w_next_sr = {r_data_sr[6:0], w_lfsr[0]};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ptr     <= 1'b0;
            r_gnt     <= 2'b00;
            r_valid   <= 1'b0;
            r_data    <= 8'h00;
            r_data_sr <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    // A seed load takes the IDLE cycle; no grant alongside it.
                    if (!w_load_en && (req != 2'b00)) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                        if (req == 2'b11) begin
                            r_gnt <= r_ptr ? 2'b10 : 2'b01;
                        end else begin
                            r_gnt <= req;
                        end
                    end
                end
                SHIFT: begin
                    r_data_sr <= w_next_sr;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_data  <= w_next_sr;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                    r_gnt   <= 2'b00;
                    // Favour the requester that was not just served.
                    r_ptr   <= r_gnt[0];
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_gnt   <= 2'b00;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign valid = r_valid;
    assign data  = r_data;
    assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_prng_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prng_arbiter
//  Description : Directed self-checking bench for prng_arbiter. Expected
//                bytes come from hand-stepping the LFSR from seed 1:
//                draws 1..4 give 80, 00, 00, 09.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prng_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        valid;
    logic [7:0]  data;
    logic        busy;
    logic        seed_load;
    logic [30:0] seed;

    int n_vec = 0;
    int n_err = 0;

    prng_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .valid     (valid),
        .data      (data),
        .busy      (busy)
`ifdef PRNG_SEED_LOAD_EN
        ,
        .seed_load (seed_load),
        .seed      (seed)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check($sformatf("%s_gnt", tag),   32'(gnt),   32'h0);
        check($sformatf("%s_valid", tag), 32'(valid), 32'h0);
        check($sformatf("%s_data", tag),  32'(data),  32'h0);
        check($sformatf("%s_busy", tag),  32'(busy),  32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b1;
        tick();
        tick();
        check_reset_state(tag);
        rst_n = 1'b0;
    endtask

    // One full draw: E0 grant, E1..E8 shift, valid after E8, idle after E9.
    // drop_at > 0 releases req after that many SHIFT edges.
    task automatic draw(input logic [1:0] r, input logic [1:0] eg,
                        input logic [7:0] ed, input int drop_at, input string tag);
        req = r;
        tick();
        check($sformatf("%s_gnt_e0", tag),  32'(gnt),   32'(eg));
        check($sformatf("%s_busy_e0", tag), 32'(busy),  32'h1);
        check($sformatf("%s_val_e0", tag),  32'(valid), 32'h0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == drop_at) req = 2'b00;
            check($sformatf("%s_gnt_e%0d", tag, k), 32'(gnt),   32'(eg));
            check($sformatf("%s_val_e%0d", tag, k), 32'(valid), 32'h0);
        end
        tick();
        check($sformatf("%s_val_e8", tag),  32'(valid), 32'h1);
        check($sformatf("%s_data_e8", tag), 32'(data),  32'(ed));
        check($sformatf("%s_gnt_e8", tag),  32'(gnt),   32'(eg));
        tick();
        check($sformatf("%s_val_e9", tag),  32'(valid), 32'h0);
        check($sformatf("%s_gnt_e9", tag),  32'(gnt),   32'h0);
        check($sformatf("%s_busy_e9", tag), 32'(busy),  32'h0);
        check($sformatf("%s_data_e9", tag), 32'(data),  32'(ed));
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = 2'b00;
        seed_load = 1'b0;
        seed      = 31'd0;

        do_reset("rst0");

        // Requester 0 alone, four back-to-back draws.
        draw(2'b01, 2'b01, 8'h80, 0, "r0_d1");
        draw(2'b01, 2'b01, 8'h00, 0, "r0_d2");
        draw(2'b01, 2'b01, 8'h00, 0, "r0_d3");
        draw(2'b01, 2'b01, 8'h09, 0, "r0_d4");

        // Reset in the 5th SHIFT cycle clears everything at once.
        tick();
        check("mid_gnt_e0", 32'(gnt), 32'h1);
        repeat (4) tick();
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b1;
        #1;
        check_reset_state("mid_rst");
        req = 2'b00;
        tick();
        rst_n = 1'b0;
        draw(2'b01, 2'b01, 8'h80, 0, "post_rst");

        // Continuous dual requests alternate; ptr favours requester 1 now.
        draw(2'b11, 2'b10, 8'h00, 0, "dual1");
        draw(2'b11, 2'b01, 8'h00, 0, "dual2");
        draw(2'b11, 2'b10, 8'h09, 0, "dual3");
        req = 2'b00;

        // Requester 0 drops req mid-draw; draw completes and ptr advances.
        do_reset("rst1");
        draw(2'b01, 2'b01, 8'h80, 3, "drop");
        check("drop_req_released", 32'(req), 32'h0);
        draw(2'b11, 2'b10, 8'h00, 0, "after_drop");
        req = 2'b00;

`ifdef PRNG_SEED_LOAD_EN
        // Zero seed acts as 1; no grant on the load cycle.
        req       = 2'b01;
        seed      = 31'd0;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        check("seed_ld_gnt",  32'(gnt),  32'h0);
        check("seed_ld_busy", 32'(busy), 32'h0);
        draw(2'b01, 2'b01, 8'h80, 0, "seed0");
        req = 2'b00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
